// File: rtl/motion_seg_pkg.sv
// Shared widths, raster defaults and state encoding for the motion segmentation blocks.
package motion_seg_pkg;

  localparam int unsigned COORD_W      = 11;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned MIN_PIX_DEF  = 64;
  localparam int unsigned CNT_W_DEF    = 19;
  localparam int unsigned SUM_W        = 28;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACCUM    = 1'b1
  } bbox_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } bbox_t;

endpackage

// File: rtl/bbox_axis_acc.sv
// Min/max tracker for one raster axis; min_c/max_c are the running values including the current pixel.
module bbox_axis_acc
  import motion_seg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               upd,
  input  logic               clear,
  input  logic [COORD_W-1:0] coord,
  output logic [COORD_W-1:0] min_c,
  output logic [COORD_W-1:0] max_c
);

  logic [COORD_W-1:0] min_q;
  logic [COORD_W-1:0] max_q;
  logic [COORD_W-1:0] min_base;
  logic [COORD_W-1:0] max_base;

  // start discards the previous partial frame before the current pixel is folded in
  always_comb begin
    min_base = start ? '1 : min_q;
    max_base = start ? '0 : max_q;
    min_c    = min_base;
    max_c    = max_base;
    if (upd) begin
      if (coord < min_base) min_c = coord;
      if (coord > max_base) max_c = coord;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clear) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_c;
      max_q <= max_c;
    end
  end

endmodule

// File: rtl/motion_bbox.sv
// Per-frame bounding box / pixel count extractor for the eroded motion mask.
// Define MOTION_BBOX_SUM_EN to add per-frame coordinate sums (sum_x/sum_y) for a downstream centroid.
module motion_bbox
  import motion_seg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned MIN_PIX  = MIN_PIX_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               in_pix,
  output logic               bbox_valid,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [CNT_W-1:0]   pix_count,
  output logic               detected
`ifdef MOTION_BBOX_SUM_EN
  ,
  output logic [SUM_W-1:0]   sum_x,
  output logic [SUM_W-1:0]   sum_y
`endif
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] H_LIM  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM  = COORD_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]   DET_TH = CNT_W'(MIN_PIX);

  bbox_state_t        state_q;
  bbox_state_t        state_d;
  logic               in_range;
  logic               sof;
  logic               eof;
  logic               start;
  logic               upd;
  logic               pub;
  logic [COORD_W-1:0] xmin_c;
  logic [COORD_W-1:0] xmax_c;
  logic [COORD_W-1:0] ymin_c;
  logic [COORD_W-1:0] ymax_c;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_c;
  logic               empty_c;
  bbox_t              bbox_q;

  assign in_range = (hpos < H_LIM) && (vpos < V_LIM);
  assign sof      = (hpos == '0) && (vpos == '0);
  assign eof      = (hpos == H_LAST) && (vpos == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_SOF;
    else        state_q <= state_d;
  end

  // A (0,0) in ACCUM is either a seamless restart or a sync-loss abort; both reinitialise
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    upd     = 1'b0;
    pub     = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        if (sof) begin
          state_d = ACCUM;
          start   = 1'b1;
          upd     = in_pix;
        end
      end
      ACCUM: begin
        start = sof;
        upd   = in_pix && in_range;
        if (eof) begin
          pub     = 1'b1;
          state_d = WAIT_SOF;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  bbox_axis_acc u_x_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .upd   (upd),
    .clear (pub),
    .coord (hpos),
    .min_c (xmin_c),
    .max_c (xmax_c)
  );

  bbox_axis_acc u_y_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .upd   (upd),
    .clear (pub),
    .coord (vpos),
    .min_c (ymin_c),
    .max_c (ymax_c)
  );

  // Saturating foreground counter
  always_comb begin
    cnt_base = start ? '0 : cnt_q;
    cnt_c    = cnt_base;
    if (upd && (cnt_base != '1)) cnt_c = cnt_base + CNT_W'(1);
  end

  assign empty_c = (cnt_c == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= pub ? '0 : cnt_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bbox_valid <= 1'b0;
      bbox_q     <= '0;
      pix_count  <= '0;
      detected   <= 1'b0;
    end else begin
      bbox_valid <= pub;
      if (pub) begin
        bbox_q.x_min <= empty_c ? '0 : xmin_c;
        bbox_q.x_max <= empty_c ? '0 : xmax_c;
        bbox_q.y_min <= empty_c ? '0 : ymin_c;
        bbox_q.y_max <= empty_c ? '0 : ymax_c;
        pix_count    <= cnt_c;
        detected     <= (cnt_c >= DET_TH);
      end
    end
  end

  assign x_min = bbox_q.x_min;
  assign x_max = bbox_q.x_max;
  assign y_min = bbox_q.y_min;
  assign y_max = bbox_q.y_max;

`ifdef MOTION_BBOX_SUM_EN
  logic [SUM_W-1:0] sx_q;
  logic [SUM_W-1:0] sy_q;
  logic [SUM_W-1:0] sx_c;
  logic [SUM_W-1:0] sy_c;

  always_comb begin
    sx_c = start ? '0 : sx_q;
    sy_c = start ? '0 : sy_q;
    if (upd) begin
      sx_c = sx_c + SUM_W'(hpos);
      sy_c = sy_c + SUM_W'(vpos);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q  <= '0;
      sy_q  <= '0;
      sum_x <= '0;
      sum_y <= '0;
    end else begin
      sx_q <= pub ? '0 : sx_c;
      sy_q <= pub ? '0 : sy_c;
      if (pub) begin
        sum_x <= sx_c;
        sum_y <= sy_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_motion_bbox.sv
// Self-checking bench for motion_bbox: frame table plus sync-loss and reset sequences, scoreboarded pulses.
module tb_motion_bbox;

  logic        clk;
  logic        rst_n;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic        in_pix;
  logic        bbox_valid;
  logic [10:0] x_min;
  logic [10:0] x_max;
  logic [10:0] y_min;
  logic [10:0] y_max;
  logic [18:0] pix_count;
  logic        detected;
`ifdef MOTION_BBOX_SUM_EN
  logic [27:0] sum_x;
  logic [27:0] sum_y;
`endif

  motion_bbox dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .in_pix     (in_pix),
    .bbox_valid (bbox_valid),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .pix_count  (pix_count),
    .detected   (detected)
`ifdef MOTION_BBOX_SUM_EN
    ,
    .sum_x      (sum_x),
    .sum_y      (sum_y)
`endif
  );

  typedef struct {
    int h0; int h1; int v0; int v1;
  } rect_t;

  typedef struct {
    rect_t a;
    rect_t b;
    int xn; int xx; int yn; int yx; int cnt; int det;
  } vec_t;

  typedef struct {
    longint due;
    int xn; int xx; int yn; int yx; int cnt; int det; int sx; int sy;
  } exp_t;

  vec_t   vecs [8];
  exp_t   q [$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     m_sx;
  int     m_sy;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic setv(input int i, input int a0, input int a1, input int a2, input int a3,
                      input int b0, input int b1, input int b2, input int b3,
                      input int xn, input int xx, input int yn, input int yx,
                      input int c, input int d);
    vecs[i].a.h0 = a0; vecs[i].a.h1 = a1; vecs[i].a.v0 = a2; vecs[i].a.v1 = a3;
    vecs[i].b.h0 = b0; vecs[i].b.h1 = b1; vecs[i].b.v0 = b2; vecs[i].b.v1 = b3;
    vecs[i].xn = xn; vecs[i].xx = xx; vecs[i].yn = yn; vecs[i].yx = yx;
    vecs[i].cnt = c; vecs[i].det = d;
  endtask

  function automatic bit in_rect(input rect_t r, input int h, input int v);
    return (h >= r.h0) && (h <= r.h1) && (v >= r.v0) && (v <= r.v1);
  endfunction

  task automatic drive(input int h, input int v, input logic p);
    @(posedge clk);
    #1;
    hpos   = 11'(h);
    vpos   = 11'(v);
    in_pix = p;
    if (p && (h < 640) && (v < 480)) begin
      m_sx += h;
      m_sy += v;
    end
  endtask

  task automatic drive_rect(input rect_t r, input int last_row);
    for (int v = r.v0; v <= r.v1 && v <= last_row; v++)
      for (int h = r.h0; h <= r.h1; h++)
        if (!(h == 0 && v == 0) && !(h == 639 && v == 479)) drive(h, v, 1'b1);
  endtask

  // Sparse raster: (0,0), foreground pixels, out-of-range noise, then the last pixel
  task automatic frame(input int i);
    exp_t e;
    m_sx = 0;
    m_sy = 0;
    drive(0, 0, in_rect(vecs[i].a, 0, 0) || in_rect(vecs[i].b, 0, 0));
    drive_rect(vecs[i].a, 479);
    drive_rect(vecs[i].b, 479);
    drive(700, 5, 1'b1);
    drive(5, 600, 1'b1);
    drive(639, 479, in_rect(vecs[i].a, 639, 479) || in_rect(vecs[i].b, 639, 479));
    e.due = cyc + 1;
    e.xn = vecs[i].xn; e.xx = vecs[i].xx; e.yn = vecs[i].yn; e.yx = vecs[i].yx;
    e.cnt = vecs[i].cnt; e.det = vecs[i].det; e.sx = m_sx; e.sy = m_sy;
    q.push_back(e);
  endtask

  task automatic partial(input rect_t r, input int last_row);
    drive(0, 0, 1'b0);
    drive_rect(r, last_row);
  endtask

  always @(negedge clk) begin
    if (rst_n && bbox_valid) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_pulse: bbox_valid=1 at cycle %0d with no frame pending", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", int'(cyc), int'(e.due));
        chk("x_min", int'(x_min), e.xn);
        chk("x_max", int'(x_max), e.xx);
        chk("y_min", int'(y_min), e.yn);
        chk("y_max", int'(y_max), e.yx);
        chk("pix_count", int'(pix_count), e.cnt);
        chk("detected", int'(detected), e.det);
`ifdef MOTION_BBOX_SUM_EN
        chk("sum_x", int'(sum_x), e.sx);
        chk("sum_y", int'(sum_y), e.sy);
`endif
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, int'(bbox_valid), 0);
    chk({tag, "_x_min"}, int'(x_min), 0);
    chk({tag, "_x_max"}, int'(x_max), 0);
    chk({tag, "_y_min"}, int'(y_min), 0);
    chk({tag, "_y_max"}, int'(y_max), 0);
    chk({tag, "_count"}, int'(pix_count), 0);
    chk({tag, "_det"}, int'(detected), 0);
`ifdef MOTION_BBOX_SUM_EN
    chk({tag, "_sum_x"}, int'(sum_x), 0);
    chk({tag, "_sum_y"}, int'(sum_y), 0);
`endif
  endtask

  initial begin
    rect_t r;
    //         a: h0  h1  v0  v1    b: h0  h1 v0 v1    xmin xmax ymin ymax count det
    setv(0,   21, 200,   6,  99,     1,  0, 1, 0,     21, 200,   6,  99, 16920, 1);
    setv(1,   21, 200,   6,  99,   206,249, 6,99,     21, 249,   6,  99, 21056, 1);
    setv(2,    1,   0,   1,   0,     1,  0, 1, 0,      0,   0,   0,   0,     0, 0);
    setv(3,  639, 639, 479, 479,     1,  0, 1, 0,    639, 639, 479, 479,     1, 0);
    setv(4,  100, 107, 200, 207,     1,  0, 1, 0,    100, 107, 200, 207,    64, 1);
    setv(5,    0,   8,   0,   6,     1,  0, 1, 0,      0,   8,   0,   6,    63, 0);
    setv(6,  300, 309, 300, 309,     1,  0, 1, 0,    300, 309, 300, 309,   100, 1);
    setv(7,   10,  10,  20,  20,     1,  0, 1, 0,     10,  10,  20,  20,     1, 0);

    rst_n  = 1'b0;
    hpos   = 11'h7ff;
    vpos   = 11'h7ff;
    in_pix = 1'b0;
    m_sx   = 0;
    m_sy   = 0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) frame(i);

    // Outputs must hold the last frame's result while the stream idles
    repeat (4) drive(1000, 1000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", int'(bbox_valid), 0);
    chk("hold_x_max", int'(x_max), 8);
    chk("hold_y_max", int'(y_max), 6);
    chk("hold_count", int'(pix_count), 63);

    // Sync loss: early (0,0) at row 200 aborts the partial frame
    r.h0 = 10; r.h1 = 20; r.v0 = 150; r.v1 = 250;
    partial(r, 199);
    frame(6);

    // Reset mid-frame discards the partial frame
    r.h0 = 21; r.h1 = 200; r.v0 = 6; r.v1 = 99;
    partial(r, 50);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    hpos  = 11'h7ff;
    vpos  = 11'h7ff;
    #3;
    check_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(639, 479, 1'b1);
    drive(100, 100, 1'b1);
    frame(7);

    drive(1000, 1000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("pending_pulses", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
